// File: rtl/alu_serial_seq.sv
// Bit-serial sequencer driving a single 1-bit ALU slice, LSB first, WIDTH cycles per op.
// Optional SLT support (opcode 0111) is enabled by defining ALU_SERIAL_SLT_EN.
module alu_serial_seq #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [3:0]       alu_op,
  output logic             busy,
  output logic             done,
  output logic             illegal,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry_out,
  output logic             slice_a,
  output logic             slice_b,
  output logic             slice_cin,
  output logic [3:0]       slice_op,
  input  logic             slice_result,
  input  logic             slice_cout
);

  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

`ifdef ALU_SERIAL_SLT_EN
  localparam bit SLT_EN = 1'b1;
`else
  localparam bit SLT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [3:0]         op_q, op_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;
  logic               cout_q, cout_d;
  logic               illegal_q, illegal_d;

  // Opcode decode for the incoming request and for the latched operation.
  logic op_in_ok;
  logic op_in_inv;
  logic op_arith;
  logic op_inv;
  logic op_slt;

  always_comb begin
    op_in_ok  = (alu_op == OP_AND) || (alu_op == OP_OR) || (alu_op == OP_ADD) ||
                (alu_op == OP_SUB) || (alu_op == OP_NOR) ||
                (SLT_EN && (alu_op == OP_SLT));
    op_in_inv = (alu_op == OP_SUB) || (alu_op == OP_SLT);
    op_arith  = (op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_SLT);
    op_inv    = (op_q == OP_SUB) || (op_q == OP_SLT);
    op_slt    = SLT_EN && (op_q == OP_SLT);
  end

  // One-hot bit select; drives operand muxing and result-bit insertion.
  logic [WIDTH-1:0] bit_sel;
  logic [WIDTH-1:0] shift_ins;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign bit_sel[gi]   = (cnt_q == CNT_W'(gi));
      assign shift_ins[gi] = bit_sel[gi] ? slice_result : shift_q[gi];
    end
  endgenerate

  logic             running;
  logic             last_bit;
  logic             a_bit;
  logic             b_bit;
  logic [WIDTH-1:0] final_res;
  logic             slt_bit;

  always_comb begin
    running  = (state_q == RUN);
    last_bit = (cnt_q == CNT_W'(WIDTH - 1));
    a_bit    = |(a_q & bit_sel);
    b_bit    = |(b_q & bit_sel);
    // Signed less-than: sum sign XOR overflow (carry into MSB ^ carry out of MSB).
    slt_bit  = slice_result ^ carry_q ^ slice_cout;
    final_res = shift_ins;
    if (op_slt) begin
      final_res = {{(WIDTH-1){1'b0}}, slt_bit};
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    carry_d   = carry_q;
    shift_d   = shift_q;
    result_d  = result_q;
    zero_d    = zero_q;
    cout_d    = cout_q;
    illegal_d = illegal_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (op_in_ok) begin
            a_d       = a_in;
            b_d       = b_in;
            op_d      = alu_op;
            cnt_d     = '0;
            carry_d   = op_in_inv;
            illegal_d = 1'b0;
            state_d   = RUN;
          end else begin
            illegal_d = 1'b1;
            result_d  = '0;
            zero_d    = 1'b1;
            cout_d    = 1'b0;
            state_d   = DONE;
          end
        end
      end
      RUN: begin
        shift_d = shift_ins;
        if (op_arith) begin
          carry_d = slice_cout;
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (last_bit) begin
          cnt_d    = '0;
          result_d = final_res;
          zero_d   = ~|final_res;
          cout_d   = op_arith ? slice_cout : 1'b0;
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      cnt_q     <= '0;
      carry_q   <= 1'b0;
      shift_q   <= '0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      cout_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      carry_q   <= carry_d;
      shift_q   <= shift_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      cout_q    <= cout_d;
      illegal_q <= illegal_d;
    end
  end

  // Slice drive is quiet outside RUN so the slice sees a benign AND of zeros.
  always_comb begin
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
    illegal   = illegal_q;
    result    = result_q;
    zero      = zero_q;
    carry_out = cout_q;
    slice_a   = running & a_bit;
    slice_b   = running & (b_bit ^ op_inv);
    slice_cin = running & carry_q;
    slice_op  = 4'b0000;
    if (running) begin
      slice_op = op_arith ? OP_ADD : op_q;
    end
  end

endmodule

// File: tb/tb_alu_serial_seq.sv
// Directed bench for alu_serial_seq with a behavioural 1-bit ALU slice attached.
// Covers SLT when ALU_SERIAL_SLT_EN is defined, otherwise checks 0111 is rejected.
module tb_alu_serial_seq;

  localparam int W     = 64;
  localparam int LIMIT = 300;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_BAD = 4'b0011;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] a_in, b_in;
  logic [3:0]   alu_op;
  logic         busy, done, illegal, zero, carry_out;
  logic [W-1:0] result;
  logic         slice_a, slice_b, slice_cin;
  logic [3:0]   slice_op;
  logic         slice_result, slice_cout;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  alu_serial_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .a_in(a_in), .b_in(b_in),
    .alu_op(alu_op), .busy(busy), .done(done), .illegal(illegal),
    .result(result), .zero(zero), .carry_out(carry_out),
    .slice_a(slice_a), .slice_b(slice_b), .slice_cin(slice_cin),
    .slice_op(slice_op), .slice_result(slice_result), .slice_cout(slice_cout)
  );

  // Behavioural 1-bit ALU slice.
  always_comb begin
    slice_result = 1'b0;
    slice_cout   = 1'b0;
    case (slice_op)
      4'b0000: slice_result = slice_a & slice_b;
      4'b0001: slice_result = slice_a | slice_b;
      4'b0010: {slice_cout, slice_result} = {1'b0, slice_a} + {1'b0, slice_b} + {1'b0, slice_cin};
      4'b1100: slice_result = ~(slice_a | slice_b);
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one op; returns cycles from the negedge after the start edge until done.
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic inject, input logic [3:0] exp_sop,
                        output int lat, output int sop_bad);
    sop_bad = 0;
    @(negedge clk);
    start = 1'b1; alu_op = op; a_in = a; b_in = b;
    @(negedge clk);
    start = 1'b0; a_in = '0; b_in = '0; alu_op = OP_AND;
    lat = 0;
    while (!done && lat < LIMIT) begin
      if (slice_op !== exp_sop) sop_bad++;
      if (inject && lat == 10) begin
        start = 1'b1; alu_op = OP_OR; a_in = ~a; b_in = 64'h3;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
  endtask

  task automatic op_check(input string tag, input logic [3:0] op,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic inject, input logic [3:0] exp_sop, input int exp_lat,
                          input logic [W-1:0] exp_res, input logic exp_zero,
                          input logic exp_cout, input logic exp_ill);
    int lat, sop_bad;
    run_op(op, a, b, inject, exp_sop, lat, sop_bad);
    $display("op %s: op=%b a=%h b=%h lat=%0d result=%h zero=%b cout=%b ill=%b",
             tag, op, a, b, lat, result, zero, carry_out, illegal);
    check({tag, ".lat"},     64'(lat), 64'(exp_lat));
    check({tag, ".sop"},     64'(sop_bad), 64'd0);
    check({tag, ".result"},  result, exp_res);
    check({tag, ".zero"},    64'(zero), 64'(exp_zero));
    check({tag, ".cout"},    64'(carry_out), 64'(exp_cout));
    check({tag, ".illegal"}, 64'(illegal), 64'(exp_ill));
    @(negedge clk);
    check({tag, ".done_pulse"}, 64'(done), 64'd0);
    check({tag, ".idle"},       64'(busy), 64'd0);
  endtask

  initial begin
    int dones;
    reset = 1'b1; start = 1'b0; a_in = '0; b_in = '0; alu_op = OP_AND;
    repeat (3) @(negedge clk);
    check("rst.busy",    64'(busy), 64'd0);
    check("rst.done",    64'(done), 64'd0);
    check("rst.illegal", 64'(illegal), 64'd0);
    check("rst.result",  result, 64'd0);
    check("rst.zero",    64'(zero), 64'd0);
    check("rst.cout",    64'(carry_out), 64'd0);
    check("rst.slice",   64'({slice_a, slice_b, slice_cin, slice_op}), 64'd0);
    reset = 1'b0;

    op_check("add5_7", OP_ADD, 64'd5, 64'd7, 1'b0, OP_ADD, W, 64'd12, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("hold.result", result, 64'd12);
    check("idle.slice",  64'({slice_a, slice_b, slice_cin, slice_op}), 64'd0);

    op_check("sub3_5", OP_SUB, 64'd3, 64'd5, 1'b0, OP_ADD, W,
             64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0);
    op_check("sub_eq", OP_SUB, 64'h1234, 64'h1234, 1'b0, OP_ADD, W, 64'd0, 1'b1, 1'b1, 1'b0);
    op_check("nor0",   OP_NOR, 64'd0, 64'd0, 1'b0, OP_NOR, W,
             64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0);
    op_check("or",     OP_OR, 64'h00A5, 64'h5A00, 1'b0, OP_OR, W, 64'h5AA5, 1'b0, 1'b0, 1'b0);
    op_check("addovf", OP_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, OP_ADD, W,
             64'd0, 1'b1, 1'b1, 1'b0);

    op_check("inject", OP_ADD, 64'h1111, 64'h2222, 1'b1, OP_ADD, W, 64'h3333, 1'b0, 1'b0, 1'b0);
    dones = 0;
    repeat (W + 4) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("inject.extra_done", 64'(dones), 64'd0);
    check("inject.result",     result, 64'h3333);

    op_check("illegal", OP_BAD, 64'd9, 64'd9, 1'b0, OP_AND, 0, 64'd0, 1'b1, 1'b0, 1'b1);
    op_check("and",     OP_AND, 64'hF0F0, 64'hFF00, 1'b0, OP_AND, W, 64'hF000, 1'b0, 1'b0, 1'b0);

    // Reset mid-ADD while bit 30 is on the slice.
    @(negedge clk);
    start = 1'b1; alu_op = OP_ADD; a_in = 64'd1; b_in = 64'd2;
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    check("abort.busy_before", 64'(busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    $display("op abort: busy=%b done=%b result=%h", busy, done, result);
    check("abort.busy",   64'(busy), 64'd0);
    check("abort.done",   64'(done), 64'd0);
    check("abort.result", result, 64'd0);
    check("abort.zero",   64'(zero), 64'd0);
    dones = 0;
    repeat (W + 4) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("abort.no_done", 64'(dones), 64'd0);
    op_check("post_abort", OP_ADD, 64'd100, 64'd23, 1'b0, OP_ADD, W, 64'd123, 1'b0, 1'b0, 1'b0);

`ifdef ALU_SERIAL_SLT_EN
    op_check("slt_m1_1", OP_SLT, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, OP_ADD, W,
             64'd1, 1'b0, 1'b1, 1'b0);
    op_check("slt_1_m1", OP_SLT, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, OP_ADD, W,
             64'd0, 1'b1, 1'b0, 1'b0);
`else
    op_check("slt_off", OP_SLT, 64'd1, 64'd2, 1'b0, OP_AND, 0, 64'd0, 1'b1, 1'b0, 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_serial_seq.md
# alu_serial_seq

Bit-serial sequencer that sits directly upstream of the 1-bit ALU slice in the datapath. Latches a full-width operation (two operands plus 4-bit ALU opcode), feeds the slice one bit per clock from LSB to MSB, ripples the slice carry through a register, and collects slice results into a full-width result word. Gives a WIDTH-bit ALU built from a single 1-bit slice at a cost of WIDTH cycles per operation.

## Interface
- WIDTH, 64: operand/result width in bits; ≥ 2.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a_in  input  WIDTH  operand A, latched on accepted start.
- b_in  input  WIDTH  operand B, latched on accepted start.
- alu_op  input  4  opcode: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 1100 NOR (0111 SLT, see Configuration).
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle completion pulse.
- illegal  output  1  high with done when opcode was unsupported.
- result  output  WIDTH  last completed result.
- zero  output  1  result == 0, registered with result.
- carry_out  output  1  final slice carry (ADD/SUB/SLT), else 0.
- slice_a, slice_b, slice_cin  output  1 each  bit-slice operand drive.
- slice_op  output  4  bit-slice opcode drive.
- slice_result, slice_cout  input  1 each  combinational bit-slice outputs.

## Operation
- FSM states IDLE, RUN, DONE. Reset → IDLE.
- IDLE: start=1 with supported opcode → latch a_in, b_in, alu_op; bit counter=0; carry register = 1 for SUB/SLT, else 0; → RUN. Unsupported opcode → latch nothing, set illegal, result=0, zero=1, carry_out=0, → DONE.
- RUN: slice_a = A[cnt], slice_b = B[cnt] ^ inv (inv=1 for SUB/SLT), slice_cin = carry register, slice_op = 0010 for ADD/SUB/SLT, else latched opcode. Each edge: slice_result shifted into result shift register at bit cnt, carry register <= slice_cout (ADD/SUB/SLT only), cnt++. Edge at cnt = WIDTH-1 → DONE; result, zero, carry_out updated at this edge.
- DONE: done=1 for exactly one cycle, → IDLE unconditionally.
- Subtraction is A + ~B + 1; carry_out = 1 means no borrow (A ≥ B unsigned).
- Logic ops (AND/OR/NOR) ignore carry; carry_out forced 0.
- start while busy ignored, not queued.
- IDLE/DONE: slice_a, slice_b, slice_cin = 0, slice_op = 0000.
- result/zero/carry_out hold between operations; overwritten only at completion. illegal cleared at next accepted start.
- reset in any state: abort, → IDLE, no done pulse, all outputs zero.

## Timing
- Reset values: busy 0, done 0, illegal 0, result 0, zero 0, carry_out 0, slice outputs 0.
- start sampled at edge E0 → RUN from E0; bits processed at edges E1..E_WIDTH; done high during cycle following E_WIDTH; IDLE after E_WIDTH+1. Latency WIDTH+1 cycles start-to-done; throughput one op per WIDTH+2 cycles minimum (start may be raised in the cycle after done).
- Illegal opcode: done one cycle after start edge.
- Slice path purely combinational within one cycle; no slice latency assumed.

## Configuration
- ALU_SERIAL_SLT_EN defined: opcode 0111 (SLT) supported. Runs as SUB; at completion result = {WIDTH-1 zeros, s ^ v} where s = sum MSB, v = carry into MSB XOR slice_cout at MSB (carry register value before the final edge captured separately); carry_out = final carry; zero from the SLT result.
- Undefined: 0111 takes the illegal path.

## Test plan
- ADD A=5, B=7 → done at start+WIDTH+1, result=12, zero=0, carry_out=0; slice_op=0010 every RUN cycle.
- SUB A=3, B=5 → result=0xFFFF_FFFF_FFFF_FFFE, carry_out=0; SUB A=B=0x1234 → result=0, zero=1, carry_out=1.
- NOR A=0, B=0 → all ones, carry_out=0; AND 0xF0F0 & 0xFF00 → 0xF000.
- start pulsed again mid-RUN with different operands → ignored; single done, original result.
- reset asserted at bit 30 of an ADD → next cycle IDLE, busy=0, result=0, no done; subsequent op correct.
- alu_op=0011 → done and illegal one cycle after start, result=0, zero=1; with ALU_SERIAL_SLT_EN, SLT A=-1, B=1 → result=1; A=1, B=-1 → result=0.
